// File: rtl/uart_ahb_loader.sv
// ---------------------------------------------------------------------------
// uart_ahb_loader
//
// Receives framed byte streams from a UART receiver and writes the payload
// words into SRAM through a single-beat AHB-Lite master port.
//
// Frame: 0xA5 | ADDR[4] LE | LEN[2] LE (word count) | LEN*4 data bytes LE |
//        CSUM (8-bit modulo sum of the data bytes)
//
// Ports
//   HCLK, HRESETN        clock, asynchronous active-low reset
//   RX_DATA, RX_VALID    received byte and its one-cycle strobe
//   HADDR .. HWDATA      AHB-Lite master outputs (word writes only)
//   HREADY, HRESP        AHB-Lite slave response
//   BUSY                 a frame is being received or drained
//   DONE / ERR           result of the last frame, held until next header
// ---------------------------------------------------------------------------
module uart_ahb_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        HCLK,
   input  logic        HRESETN,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_VALID,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HWRITE,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR
);

   localparam int GAP_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] TRANS_IDLE    = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ  = 2'b10;

   typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM} state_t;
   typedef enum logic [1:0] {AIDLE, APHASE, DPHASE} ahb_state_t;

   state_t           state;
   ahb_state_t       ahb_state;
   logic [1:0]       byte_cnt;
   logic [23:0]      addr_shift;
   logic [7:0]       len_lo;
   logic [23:0]      word_shift;
   logic [15:0]      words_left;
   logic [7:0]       sum;
   logic [GAP_W-1:0] gap_cnt;
   logic             csum_got;
   logic             csum_ok;
   logic             draining;
   logic             wr_req;
   logic [31:0]      wr_word;
   logic             addr_load;
   logic [31:0]      load_addr;
   logic [31:0]      cur_addr;
   logic             ahb_err;
   logic             write_pending;
   logic             timer_run;

   // Single-beat word writes with fixed attributes.
   assign HSIZE     = 3'b010;
   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;

   // A write is outstanding from the request pulse until its data phase ends.
   assign write_pending = wr_req || (ahb_state != AIDLE);

   // The inter-byte timer only runs while waiting for frame bytes; it stops
   // once the checksum is in or while an aborted frame drains its last write.
   assign timer_run = (state != IDLE) && !draining && !csum_got;

   // Frame receiver. Error paths in priority order: bus error response,
   // draining an aborted frame, inter-byte timeout, then normal parsing.
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state      <= IDLE;
         byte_cnt   <= '0;
         addr_shift <= '0;
         len_lo     <= '0;
         word_shift <= '0;
         words_left <= '0;
         sum        <= '0;
         gap_cnt    <= '0;
         csum_got   <= 1'b0;
         csum_ok    <= 1'b0;
         draining   <= 1'b0;
         wr_req     <= 1'b0;
         wr_word    <= '0;
         addr_load  <= 1'b0;
         load_addr  <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         ERR        <= 1'b0;
      end else begin
         wr_req    <= 1'b0;
         addr_load <= 1'b0;

         if (RX_VALID || !timer_run)
            gap_cnt <= '0;
         else
            gap_cnt <= gap_cnt + 1'b1;

         if (state != IDLE && ahb_err) begin
            state    <= IDLE;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b1;
            draining <= 1'b0;
            csum_got <= 1'b0;
         end else if (draining) begin
            // Aborted frame: bytes are ignored until the in-flight write ends.
            if (!write_pending) begin
               state    <= IDLE;
               BUSY     <= 1'b0;
               draining <= 1'b0;
               csum_got <= 1'b0;
            end
         end else if (timer_run && !RX_VALID && gap_cnt == GAP_LAST) begin
            ERR      <= 1'b1;
            draining <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (RX_VALID && RX_DATA == 8'hA5 && !write_pending) begin
                     state    <= ADDR;
                     byte_cnt <= '0;
                     sum      <= '0;
                     csum_got <= 1'b0;
                     csum_ok  <= 1'b0;
                     BUSY     <= 1'b1;
                     DONE     <= 1'b0;
                     ERR      <= 1'b0;
                  end
               end
               ADDR: begin
                  if (RX_VALID) begin
                     byte_cnt <= byte_cnt + 2'd1;
                     if (byte_cnt == 2'd3) begin
                        // Word-align the start address.
                        load_addr <= {RX_DATA, addr_shift} & 32'hFFFF_FFFC;
                        addr_load <= 1'b1;
                        state     <= LEN;
                     end else begin
                        addr_shift <= {RX_DATA, addr_shift[23:8]};
                     end
                  end
               end
               LEN: begin
                  if (RX_VALID) begin
                     if (byte_cnt == 2'd0) begin
                        len_lo   <= RX_DATA;
                        byte_cnt <= 2'd1;
                     end else begin
                        words_left <= {RX_DATA, len_lo};
                        byte_cnt   <= '0;
                        state      <= ({RX_DATA, len_lo} == 16'd0) ? CSUM : DATA;
                     end
                  end
               end
               DATA: begin
                  if (RX_VALID) begin
                     sum      <= sum + RX_DATA;
                     byte_cnt <= byte_cnt + 2'd1;
                     if (byte_cnt == 2'd3) begin
                        if (write_pending) begin
                           // Overrun: previous word still on the bus.
                           ERR      <= 1'b1;
                           draining <= 1'b1;
                        end else begin
                           wr_req     <= 1'b1;
                           wr_word    <= {RX_DATA, word_shift};
                           words_left <= words_left - 16'd1;
                           if (words_left == 16'd1)
                              state <= CSUM;
                        end
                     end else begin
                        word_shift <= {RX_DATA, word_shift[23:8]};
                     end
                  end
               end
               CSUM: begin
                  if (!csum_got) begin
                     if (RX_VALID) begin
                        csum_got <= 1'b1;
                        csum_ok  <= (RX_DATA == sum);
                     end
                  end else if (!write_pending) begin
                     // Result is reported only after the last write retires.
                     state    <= IDLE;
                     BUSY     <= 1'b0;
                     DONE     <= csum_ok;
                     ERR      <= !csum_ok;
                     csum_got <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // AHB-Lite master: one NONSEQ word write per request, no pipelining.
   // HWDATA is loaded with the address phase and held through the data phase.
   // The write address advances only on an OKAY completion.
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         ahb_state <= AIDLE;
         HADDR     <= '0;
         HTRANS    <= TRANS_IDLE;
         HWRITE    <= 1'b0;
         HWDATA    <= '0;
         cur_addr  <= '0;
         ahb_err   <= 1'b0;
      end else begin
         ahb_err <= 1'b0;
         if (addr_load)
            cur_addr <= load_addr;
         case (ahb_state)
            AIDLE: begin
               if (wr_req) begin
                  HADDR     <= cur_addr;
                  HTRANS    <= TRANS_NONSEQ;
                  HWRITE    <= 1'b1;
                  HWDATA    <= wr_word;
                  ahb_state <= APHASE;
               end
            end
            APHASE: begin
               if (HREADY) begin
                  HTRANS    <= TRANS_IDLE;
                  HWRITE    <= 1'b0;
                  ahb_state <= DPHASE;
               end
            end
            DPHASE: begin
               if (HREADY) begin
                  ahb_state <= AIDLE;
                  if (HRESP)
                     ahb_err <= 1'b1;
                  else
                     cur_addr <= cur_addr + 32'd4;
               end
            end
            default: ahb_state <= AIDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_ahb_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_ahb_loader
//
// Self-checking bench for uart_ahb_loader. A behavioural AHB slave records
// completed writes; each test task builds frames, derives expected writes and
// the checksum result from the frame contents, and compares.
// ---------------------------------------------------------------------------
module tb_uart_ahb_loader;

   localparam int TO = 100;

   logic        HCLK = 1'b0;
   logic        HRESETN = 1'b0;
   logic [7:0]  RX_DATA = 8'h00;
   logic        RX_VALID = 1'b0;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HWRITE;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic        HREADY = 1'b1;
   logic        HRESP = 1'b0;
   logic        BUSY;
   logic        DONE;
   logic        ERR;

   int checks = 0;
   int errors = 0;

   // Slave-side record of the bus.
   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   int          got_cycles[$];
   int          nonseq_cnt = 0;
   int          hwdata_moves = 0;
   int          hwrite_bad = 0;
   int          wait_cfg = -1;
   int          err_on_write = -1;
   bit          in_dphase = 1'b0;
   bit          dp_err = 1'b0;
   int          dp_wait = 0;
   int          dp_cycles = 0;
   logic [31:0] dp_addr = '0;
   logic [31:0] dp_data = '0;

   // Current frame payload.
   logic [31:0] words[$];

   always #5 HCLK = ~HCLK;

   uart_ahb_loader #(.TIMEOUT_CYCLES(TO)) dut (
      .HCLK(HCLK), .HRESETN(HRESETN), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
      .HPROT(HPROT), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRESP(HRESP), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   // Behavioural AHB slave: decides HREADY/HRESP on the falling edge for the
   // next rising edge, and logs each completed OKAY write.
   initial begin
      forever begin
         @(negedge HCLK);
         if (!HRESETN) begin
            in_dphase = 1'b0;
            HREADY = 1'b1;
            HRESP = 1'b0;
         end else if (in_dphase) begin
            if (dp_cycles == 0) dp_data = HWDATA;
            else if (HWDATA !== dp_data) hwdata_moves++;
            dp_cycles++;
            if (dp_err) begin
               if (dp_wait > 0) begin
                  HREADY = 1'b0; HRESP = 1'b1; dp_wait = 0;
               end else begin
                  HREADY = 1'b1; HRESP = 1'b1; in_dphase = 1'b0;
               end
            end else if (dp_wait > 0) begin
               HREADY = 1'b0; HRESP = 1'b0; dp_wait--;
            end else begin
               HREADY = 1'b1; HRESP = 1'b0; in_dphase = 1'b0;
               got_addr.push_back(dp_addr);
               got_data.push_back(dp_data);
               got_cycles.push_back(dp_cycles);
            end
         end else begin
            HREADY = 1'b1;
            HRESP = 1'b0;
            if (HTRANS === 2'b10) begin
               if (HWRITE !== 1'b1) hwrite_bad++;
               nonseq_cnt++;
               in_dphase = 1'b1;
               dp_addr = HADDR;
               dp_cycles = 0;
               dp_err = (err_on_write == nonseq_cnt - 1);
               dp_wait = dp_err ? 1 : ((wait_cfg >= 0) ? wait_cfg : int'($urandom_range(0, 3)));
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Sends one byte as a single-cycle strobe, then idles for gap cycles.
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      RX_DATA = b;
      RX_VALID = 1'b1;
      @(posedge HCLK); #1;
      RX_VALID = 1'b0;
      repeat (gap) begin @(posedge HCLK); #1; end
   endtask

   // Sends a full frame built from the words queue.
   task automatic send_frame(input logic [31:0] addr, input logic [7:0] cs,
                             input int gap_lo, input int gap_hi);
      logic [15:0] len;
      logic [31:0] w;
      len = 16'(words.size());
      applyStimulus(8'hA5, $urandom_range(gap_lo, gap_hi));
      for (int i = 0; i < 4; i++) applyStimulus(addr[8*i +: 8], $urandom_range(gap_lo, gap_hi));
      applyStimulus(len[7:0], $urandom_range(gap_lo, gap_hi));
      applyStimulus(len[15:8], $urandom_range(gap_lo, gap_hi));
      foreach (words[i]) begin
         w = words[i];
         for (int j = 0; j < 4; j++) applyStimulus(w[8*j +: 8], $urandom_range(gap_lo, gap_hi));
      end
      applyStimulus(cs, $urandom_range(gap_lo, gap_hi));
   endtask

   task automatic wait_not_busy(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (BUSY === 1'b0) begin ok = 1'b1; break; end
         @(posedge HCLK); #1;
      end
   endtask

   task automatic clear_mon();
      got_addr.delete(); got_data.delete(); got_cycles.delete();
      nonseq_cnt = 0; hwdata_moves = 0; hwrite_bad = 0;
   endtask

   // Reference checksum: byte-wise modulo-256 sum of the payload.
   function automatic logic [7:0] model_csum();
      int unsigned total = 0;
      foreach (words[i])
         for (int j = 0; j < 4; j++) total += 32'((words[i] >> (8 * j)) & 32'hFF);
      return 8'(total);
   endfunction

   task automatic test_reset();
      repeat (3) @(posedge HCLK); #1;
      checks++; if (HTRANS !== 2'b00) begin errors++; $display("[TB] FAIL reset_htrans: got %0h expected 0", HTRANS); end
      checks++; if (HWRITE !== 1'b0) begin errors++; $display("[TB] FAIL reset_hwrite: got %0b expected 0", HWRITE); end
      checks++; if (HADDR !== 32'h0) begin errors++; $display("[TB] FAIL reset_haddr: got %0h expected 0", HADDR); end
      checks++; if (HWDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_hwdata: got %0h expected 0", HWDATA); end
      checks++; if ({BUSY, DONE, ERR} !== 3'b000) begin errors++; $display("[TB] FAIL reset_status: got %0b expected 000", {BUSY, DONE, ERR}); end
      checks++; if ({HSIZE, HBURST, HPROT, HMASTLOCK} !== {3'b010, 3'b000, 4'b0011, 1'b0}) begin errors++;
         $display("[TB] FAIL const_attrs: got %0h/%0h/%0h/%0b expected 2/0/3/0", HSIZE, HBURST, HPROT, HMASTLOCK); end
      HRESETN = 1'b1;
      repeat (2) begin @(posedge HCLK); #1; end
      checks++; if ({BUSY, HTRANS} !== 3'b000) begin errors++; $display("[TB] FAIL post_reset_idle: got %0b expected 000", {BUSY, HTRANS}); end
   endtask

   task automatic test_directed_frame(input logic [7:0] cs, input bit expect_done);
      bit ok;
      clear_mon();
      words.delete(); words.push_back(32'h44332211); words.push_back(32'h88776655);
      send_frame(32'h80000000, cs, 2, 4);
      wait_not_busy(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL frame_timeout: BUSY stuck, expected 0"); end
      checks++; if (got_addr.size() != 2) begin errors++; $display("[TB] FAIL frame_wr_count: got %0d expected 2", got_addr.size()); end
      else begin
         checks++; if (got_addr[0] !== 32'h80000000 || got_data[0] !== 32'h44332211) begin errors++;
            $display("[TB] FAIL frame_wr0: got %0h@%0h expected 44332211@80000000", got_data[0], got_addr[0]); end
         checks++; if (got_addr[1] !== 32'h80000004 || got_data[1] !== 32'h88776655) begin errors++;
            $display("[TB] FAIL frame_wr1: got %0h@%0h expected 88776655@80000004", got_data[1], got_addr[1]); end
      end
      checks++; if (DONE !== expect_done || ERR !== !expect_done) begin errors++;
         $display("[TB] FAIL frame_result: got DONE=%0b ERR=%0b expected DONE=%0b", DONE, ERR, expect_done); end
      checks++; if (hwrite_bad != 0) begin errors++; $display("[TB] FAIL frame_hwrite: got %0d bad expected 0", hwrite_bad); end
   endtask

   task automatic test_wait_states();
      bit ok;
      clear_mon();
      wait_cfg = 3;
      words.delete(); words.push_back($urandom); words.push_back($urandom);
      send_frame(32'h00002000, model_csum(), 2, 4);
      wait_not_busy(ok);
      wait_cfg = -1;
      checks++; if (!ok || got_cycles.size() != 2) begin errors++; $display("[TB] FAIL ws_count: got %0d writes expected 2", got_cycles.size()); end
      else begin
         checks++; if (got_cycles[0] != 4 || got_cycles[1] != 4) begin errors++;
            $display("[TB] FAIL ws_dphase_len: got %0d/%0d expected 4/4", got_cycles[0], got_cycles[1]); end
         checks++; if (got_addr[1] !== got_addr[0] + 32'd4 || got_data[1] !== words[1]) begin errors++;
            $display("[TB] FAIL ws_second_write: got %0h@%0h expected %0h@%0h", got_data[1], got_addr[1], words[1], got_addr[0] + 32'd4); end
      end
      checks++; if (hwdata_moves != 0) begin errors++; $display("[TB] FAIL ws_hwdata_stable: got %0d changes expected 0", hwdata_moves); end
      checks++; if (DONE !== 1'b1) begin errors++; $display("[TB] FAIL ws_done: got %0b expected 1", DONE); end
   endtask

   task automatic test_hresp_error();
      bit ok;
      clear_mon();
      err_on_write = 0;
      words.delete(); words.push_back(32'h44332211); words.push_back(32'h88776655);
      send_frame(32'h80000000, 8'h64, 3, 4);
      wait_not_busy(ok);
      repeat (10) begin @(posedge HCLK); #1; end
      err_on_write = -1;
      checks++; if (!ok || BUSY !== 1'b0) begin errors++; $display("[TB] FAIL hresp_busy: got %0b expected 0", BUSY); end
      checks++; if (ERR !== 1'b1 || DONE !== 1'b0) begin errors++; $display("[TB] FAIL hresp_err: got ERR=%0b DONE=%0b expected 1/0", ERR, DONE); end
      checks++; if (nonseq_cnt != 1) begin errors++; $display("[TB] FAIL hresp_nonseq: got %0d expected 1", nonseq_cnt); end
   endtask

   task automatic test_overrun();
      bit ok;
      clear_mon();
      wait_cfg = 40;
      words.delete(); words.push_back(32'h44332211); words.push_back(32'h88776655);
      send_frame(32'h00003000, 8'h64, 2, 2);
      wait_not_busy(ok);
      wait_cfg = -1;
      checks++; if (!ok) begin errors++; $display("[TB] FAIL overrun_busy: BUSY stuck, expected 0"); end
      checks++; if (ERR !== 1'b1 || DONE !== 1'b0) begin errors++; $display("[TB] FAIL overrun_err: got ERR=%0b DONE=%0b expected 1/0", ERR, DONE); end
      checks++; if (nonseq_cnt != 1 || got_addr.size() != 1) begin errors++;
         $display("[TB] FAIL overrun_writes: got %0d/%0d expected 1/1", nonseq_cnt, got_addr.size()); end
   endtask

   task automatic test_timeout();
      bit ok;
      clear_mon();
      applyStimulus(8'hA5, 3);
      applyStimulus(8'h00, 3); applyStimulus(8'h10, 3); applyStimulus(8'h00, 3); applyStimulus(8'h00, 3);
      applyStimulus(8'h02, 3); applyStimulus(8'h00, 3);
      for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 3);
      applyStimulus(8'h5C, 0);
      repeat (TO - 1) begin @(posedge HCLK); #1; end
      checks++; if (ERR !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early: got ERR=%0b expected 0", ERR); end
      @(posedge HCLK); #1;
      checks++; if (ERR !== 1'b1) begin errors++; $display("[TB] FAIL timeout_at_limit: got ERR=%0b expected 1", ERR); end
      repeat (3) begin @(posedge HCLK); #1; end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy: got %0b expected 0", BUSY); end
      clear_mon();
      words.delete(); words.push_back($urandom);
      send_frame(32'h00004000, model_csum(), 1, 5);
      wait_not_busy(ok);
      checks++; if (!ok || DONE !== 1'b1 || ERR !== 1'b0 || got_data.size() != 1) begin errors++;
         $display("[TB] FAIL timeout_recover: got DONE=%0b ERR=%0b writes=%0d expected 1/0/1", DONE, ERR, got_data.size()); end
   endtask

   task automatic test_len_zero_and_wrap();
      bit ok;
      clear_mon();
      words.delete();
      send_frame(32'h12345678, 8'h00, 1, 3);
      wait_not_busy(ok);
      checks++; if (!ok || DONE !== 1'b1 || nonseq_cnt != 0) begin errors++;
         $display("[TB] FAIL len0: got DONE=%0b transfers=%0d expected 1/0", DONE, nonseq_cnt); end
      clear_mon();
      words.push_back($urandom); words.push_back($urandom);
      send_frame(32'hFFFFFFFC, model_csum(), 1, 4);
      wait_not_busy(ok);
      checks++; if (!ok || got_addr.size() != 2) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 2", got_addr.size()); end
      else begin
         checks++; if (got_addr[0] !== 32'hFFFFFFFC || got_addr[1] !== 32'h00000000) begin errors++;
            $display("[TB] FAIL wrap_addr: got %0h,%0h expected fffffffc,0", got_addr[0], got_addr[1]); end
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      clear_mon();
      applyStimulus(8'hA5, 3);
      applyStimulus(8'h00, 3); applyStimulus(8'h00, 3); applyStimulus(8'h01, 3); applyStimulus(8'h00, 3);
      applyStimulus(8'h02, 3); applyStimulus(8'h00, 3);
      for (int i = 1; i <= 6; i++) applyStimulus(8'(i), 3);
      HRESETN = 1'b0;
      #1;
      checks++; if ({BUSY, HTRANS, HADDR, HWDATA} !== '0) begin errors++;
         $display("[TB] FAIL midreset_outputs: got BUSY=%0b HTRANS=%0h HADDR=%0h expected 0", BUSY, HTRANS, HADDR); end
      repeat (3) begin @(posedge HCLK); #1; end
      HRESETN = 1'b1;
      clear_mon();
      for (int i = 7; i <= 11; i++) applyStimulus(8'(i), 3);
      repeat (20) begin @(posedge HCLK); #1; end
      checks++; if (nonseq_cnt != 0 || BUSY !== 1'b0) begin errors++;
         $display("[TB] FAIL midreset_quiet: got transfers=%0d BUSY=%0b expected 0/0", nonseq_cnt, BUSY); end
      wait_not_busy(ok);
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 8; f++) begin
         int n;
         logic [31:0] base;
         logic [31:0] exp_addr;
         logic [7:0] cs;
         bit corrupt;
         bit ok;
         n = $urandom_range(1, 5);
         base = $urandom;
         corrupt = ($urandom_range(0, 3) == 0);
         words.delete();
         for (int i = 0; i < n; i++) words.push_back($urandom);
         cs = model_csum();
         if (corrupt) cs = cs + 8'($urandom_range(1, 255));
         clear_mon();
         send_frame(base, cs, 2, 5);
         wait_not_busy(ok);
         checks++; if (!ok || got_addr.size() != n) begin errors++;
            $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", f, got_addr.size(), n); end
         for (int i = 0; i < n && i < got_addr.size(); i++) begin
            exp_addr = (base & 32'hFFFFFFFC) + 32'(4 * i);
            checks++; if (got_addr[i] !== exp_addr || got_data[i] !== words[i]) begin errors++;
               $display("[TB] FAIL rand_write[%0d.%0d]: got %0h@%0h expected %0h@%0h", f, i, got_data[i], got_addr[i], words[i], exp_addr); end
         end
         checks++; if (DONE !== !corrupt || ERR !== corrupt) begin errors++;
            $display("[TB] FAIL rand_result[%0d]: got DONE=%0b ERR=%0b expected DONE=%0b", f, DONE, ERR, !corrupt); end
      end
   endtask

   initial begin
      test_reset();
      test_directed_frame(8'h64, 1'b1);
      test_directed_frame(8'h65, 1'b0);
      test_wait_states();
      test_hresp_error();
      test_overrun();
      test_timeout();
      test_len_zero_and_wrap();
      test_mid_reset();
      test_random_frames();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
